// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two producers/decode and the register-file write arbiter.
interface regfile_wb_arbiter_if #(parameter int AW = 2);
  logic        a_valid, a_ready;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        m_valid, m_ready;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteD;
  logic [4:0]  q1_reg, q2_reg;
  logic        q1_hit, q2_hit;
  logic [31:0] q1_data, q2_data;
  logic [AW:0] count;

  modport master (
    output a_valid, a_reg, a_data, m_valid, m_reg, m_data, q1_reg, q2_reg,
    input  a_ready, m_ready, RegWrite, WriteReg, WriteD,
           q1_hit, q2_hit, q1_data, q2_data, count
  );

  modport slave (
    input  a_valid, a_reg, a_data, m_valid, m_reg, m_data, q1_reg, q2_reg,
    output a_ready, m_ready, RegWrite, WriteReg, WriteD,
           q1_hit, q2_hit, q1_data, q2_data, count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-producer writeback arbiter feeding the register file write port through an in-order FIFO.
// Optional REGFILE_WB_FORWARD_EN: return youngest pending data on lookup hits.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic clk,
  input  logic rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [4:0]       entReg  [DEPTH];
  logic [31:0]      entData [DEPTH];
  logic [DEPTH-1:0] entVld;
  logic [AW-1:0]    rdPtr, wrPtr, mIdx;
  logic [AW:0]      cnt, free;
  logic             aNeed, aPush, mPush, pop;

  // Free space comes from the registered count only; the same-cycle pop is not credited.
  assign free  = DEPTH_C - cnt;
  assign aNeed = bus.a_valid && (bus.a_reg != 5'd0);
  assign bus.a_ready = !rst && (free >= (AW+1)'(1));
  assign bus.m_ready = !rst && ((free >= (AW+1)'(2)) || ((free == (AW+1)'(1)) && !aNeed));

  // r0 requests handshake normally but never occupy a slot.
  assign aPush = aNeed && bus.a_ready;
  assign mPush = bus.m_valid && bus.m_ready && (bus.m_reg != 5'd0);
  assign pop   = (cnt != '0);
  assign mIdx  = wrPtr + AW'(aPush);

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      cnt    <= '0;
      entVld <= '0;
    end else begin
      if (pop) begin
        entVld[rdPtr] <= 1'b0;
        rdPtr         <= rdPtr + AW'(1);
      end
      if (aPush) begin
        entVld[wrPtr]  <= 1'b1;
        entReg[wrPtr]  <= bus.a_reg;
        entData[wrPtr] <= bus.a_data;
      end
      if (mPush) begin
        entVld[mIdx]  <= 1'b1;
        entReg[mIdx]  <= bus.m_reg;
        entData[mIdx] <= bus.m_data;
      end
      wrPtr <= wrPtr + AW'(aPush) + AW'(mPush);
      cnt   <= cnt + (AW+1)'(aPush) + (AW+1)'(mPush) - (AW+1)'(pop);
    end
  end

  always @(posedge clk) begin
    if (!rst) assert (cnt <= DEPTH_C);
  end

  assign bus.RegWrite = pop;
  assign bus.WriteReg = entReg[rdPtr];
  assign bus.WriteD   = entData[rdPtr];
  assign bus.count    = cnt;

  function automatic logic hitOf(input logic [4:0] q);
    logic h;
    h = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (entVld[i] && (entReg[i] == q)) h = 1'b1;
    return h && (q != 5'd0);
  endfunction

`ifdef REGFILE_WB_FORWARD_EN
  // Walk oldest to youngest so the last match wins.
  function automatic logic [31:0] fwdOf(input logic [4:0] q);
    logic [31:0]   d;
    logic [AW-1:0] idx;
    d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr + AW'(i);
      if (entVld[idx] && (entReg[idx] == q)) d = entData[idx];
    end
    return (q != 5'd0) ? d : 32'd0;
  endfunction

  assign bus.q1_data = fwdOf(bus.q1_reg);
  assign bus.q2_data = fwdOf(bus.q2_reg);
`else
  assign bus.q1_data = 32'd0;
  assign bus.q2_data = 32'd0;
`endif

  assign bus.q1_hit = hitOf(bus.q1_reg);
  assign bus.q2_hit = hitOf(bus.q2_reg);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter plus stream/reset corner sequences.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  regfile_wb_arbiter_if #(.AW(2)) bus ();
  regfile_wb_arbiter #(.DEPTH(4), .AW(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        av; logic [4:0] ar; logic [31:0] ad;
    logic        mv; logic [4:0] mr; logic [31:0] md;
    logic [4:0]  q1;
    logic        eAr, eMr, eRw;
    logic [4:0]  eWr; logic [31:0] eWd;
    logic [2:0]  eCnt;
    logic        eHit;
    logic [31:0] eFwd;
  } vec_t;

  vec_t vt [17];

  function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                              logic mv, logic [4:0] mr, logic [31:0] md, logic [4:0] q1,
                              logic eAr, logic eMr, logic eRw, logic [4:0] eWr,
                              logic [31:0] eWd, logic [2:0] eCnt, logic eHit, logic [31:0] eFwd);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md; v.q1 = q1;
    v.eAr = eAr; v.eMr = eMr; v.eRw = eRw; v.eWr = eWr; v.eWd = eWd;
    v.eCnt = eCnt; v.eHit = eHit; v.eFwd = eFwd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h @%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwdExp(input logic [31:0] d);
`ifdef REGFILE_WB_FORWARD_EN
    return d;
`else
    return 32'd0 & d;
`endif
  endfunction

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
    bus.m_valid = mv; bus.m_reg = mr; bus.m_data = md;
  endtask

  initial begin
    // idle, A r5, drain, A+M same reg, r0 drop, fill to 3, near-full priority, r0 exclusion
    vt[0]  = mk(0,0,0,          0,0,0,          0, 1,1,0, 0,0,          0,0,0);
    vt[1]  = mk(1,5,32'hDEADBEEF,0,0,0,         5, 1,1,0, 0,0,          0,0,0);
    vt[2]  = mk(0,0,0,          0,0,0,          5, 1,1,1, 5,32'hDEADBEEF,1,1,32'hDEADBEEF);
    vt[3]  = mk(0,0,0,          0,0,0,          5, 1,1,0, 0,0,          0,0,0);
    vt[4]  = mk(1,3,32'h11,     1,3,32'h22,     3, 1,1,0, 0,0,          0,0,0);
    vt[5]  = mk(0,0,0,          0,0,0,          3, 1,1,1, 3,32'h11,     2,1,32'h22);
    vt[6]  = mk(0,0,0,          0,0,0,          3, 1,1,1, 3,32'h22,     1,1,32'h22);
    vt[7]  = mk(0,0,0,          1,0,32'h99,     0, 1,1,0, 0,0,          0,0,0);
    vt[8]  = mk(1,1,32'hA1,     1,2,32'hB2,     0, 1,1,0, 0,0,          0,0,0);
    vt[9]  = mk(1,4,32'hA4,     1,6,32'hB6,     2, 1,1,1, 1,32'hA1,     2,1,32'hB2);
    vt[10] = mk(1,7,32'hA7,     1,8,32'hB8,     7, 1,0,1, 2,32'hB2,     3,0,0);
    vt[11] = mk(0,0,0,          1,8,32'hB8,     6, 1,1,1, 4,32'hA4,     3,1,32'hB6);
    vt[12] = mk(1,0,32'hC0,     1,9,32'hB9,     8, 1,1,1, 6,32'hB6,     3,1,32'hB8);
    vt[13] = mk(0,0,0,          0,0,0,          9, 1,1,1, 7,32'hA7,     3,1,32'hB9);
    vt[14] = mk(0,0,0,          0,0,0,          7, 1,1,1, 8,32'hB8,     2,0,0);
    vt[15] = mk(0,0,0,          0,0,0,          9, 1,1,1, 9,32'hB9,     1,1,32'hB9);
    vt[16] = mk(0,0,0,          0,0,0,          0, 1,1,0, 0,0,          0,0,0);

    rst = 1'b1;
    drive(0,0,0,0,0,0);
    bus.q1_reg = 0; bus.q2_reg = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_ready", {31'd0, bus.a_ready}, 0);
    chk("rst_m_ready", {31'd0, bus.m_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_count", {29'd0, bus.count}, 0);
    chk("rst_regwrite", {31'd0, bus.RegWrite}, 0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vt[i].av, vt[i].ar, vt[i].ad, vt[i].mv, vt[i].mr, vt[i].md);
      bus.q1_reg = vt[i].q1;
      #1;
      chk($sformatf("v%0d_a_ready", i), {31'd0, bus.a_ready}, {31'd0, vt[i].eAr});
      chk($sformatf("v%0d_m_ready", i), {31'd0, bus.m_ready}, {31'd0, vt[i].eMr});
      chk($sformatf("v%0d_regwrite", i), {31'd0, bus.RegWrite}, {31'd0, vt[i].eRw});
      if (vt[i].eRw) begin
        chk($sformatf("v%0d_writereg", i), {27'd0, bus.WriteReg}, {27'd0, vt[i].eWr});
        chk($sformatf("v%0d_writed", i), bus.WriteD, vt[i].eWd);
      end
      chk($sformatf("v%0d_count", i), {29'd0, bus.count}, {29'd0, vt[i].eCnt});
      chk($sformatf("v%0d_q1_hit", i), {31'd0, bus.q1_hit}, {31'd0, vt[i].eHit});
      chk($sformatf("v%0d_q1_data", i), bus.q1_data, fwdExp(vt[i].eFwd));
    end

    // sustained A stream: one in, one out every cycle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1, 5'((i % 31) + 1), 32'h1000 + i, 0, 0, 0);
      #1;
      chk($sformatf("s%0d_a_ready", i), {31'd0, bus.a_ready}, 1);
      chk($sformatf("s%0d_count", i), {29'd0, bus.count}, (i == 0) ? 0 : 1);
      if (i > 0) begin
        chk($sformatf("s%0d_regwrite", i), {31'd0, bus.RegWrite}, 1);
        chk($sformatf("s%0d_writereg", i), {27'd0, bus.WriteReg}, (i - 1) % 31 + 1);
        chk($sformatf("s%0d_writed", i), bus.WriteD, 32'h1000 + i - 1);
      end
    end
    @(negedge clk);
    drive(0,0,0,0,0,0);
    #1;
    chk("s_last_writereg", {27'd0, bus.WriteReg}, 20);
    chk("s_last_writed", bus.WriteD, 32'h1000 + 19);
    @(negedge clk);
    #1;
    chk("s_done_regwrite", {31'd0, bus.RegWrite}, 0);

    // reset mid-drain with three entries pending
    @(negedge clk);
    drive(1, 10, 32'h10A, 1, 11, 32'h10B);
    @(negedge clk);
    drive(1, 12, 32'h10C, 1, 13, 32'h10D);
    @(negedge clk);
    drive(0,0,0,0,0,0);
    bus.q1_reg = 11; bus.q2_reg = 13;
    rst = 1'b1;
    #1;
    chk("r_pre_count", {29'd0, bus.count}, 3);
    chk("r_pre_q2_hit", {31'd0, bus.q2_hit}, 1);
    chk("r_pre_q2_data", bus.q2_data, fwdExp(32'h10D));
    chk("r_pre_q1_hit", {31'd0, bus.q1_hit}, 1);
    chk("r_in_a_ready", {31'd0, bus.a_ready}, 0);
    chk("r_in_m_ready", {31'd0, bus.m_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.q1_reg = 12;
    #1;
    chk("r_post_count", {29'd0, bus.count}, 0);
    chk("r_post_regwrite", {31'd0, bus.RegWrite}, 0);
    chk("r_post_q1_hit", {31'd0, bus.q1_hit}, 0);
    chk("r_post_q2_hit", {31'd0, bus.q2_hit}, 0);
    chk("r_post_a_ready", {31'd0, bus.a_ready}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writer-side front end for the 32x32 register file's single write port (RegWrite/WriteReg/WriteD).
- Accepts writeback requests from two producers, the ALU path (A) and the memory/multi-cycle path (M), over valid/ready handshakes.
- Buffers accepted requests in a small in-order FIFO and drains one write per cycle into the register file.
- Exposes pending-write lookup so decode can detect RAW hazards on buffered writes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  ALU writeback request.
- a_ready  out  1  ALU request accepted this cycle.
- a_reg  in  5  ALU destination register.
- a_data  in  32  ALU result.
- m_valid  in  1  memory-path writeback request.
- m_ready  out  1  memory request accepted this cycle.
- m_reg  in  5  memory destination register.
- m_data  in  32  memory/multi-cycle result.
- RegWrite  out  1  register-file write enable.
- WriteReg  out  5  register-file write address.
- WriteD  out  32  register-file write data.
- q1_reg, q2_reg  in  5 each  lookup addresses (decode's read registers).
- q1_hit, q2_hit  out  1 each  a pending buffered write targets qN_reg.
- q1_data, q2_data  out  32 each  forwarded value (see Optional Feature).
- count  out  AW+1  current occupancy.

Behaviour:
- Reset: rst sampled high at posedge clears rd_ptr, wr_ptr, count and all entry valid bits. Pending entries are discarded, including on reset mid-operation. Afterwards RegWrite=0, a_ready=0/m_ready=0 only while rst=1, and q*_hit=0.
- Free slots: free = DEPTH - count, using the registered count only. The same-cycle pop is not credited.
- a_ready = !rst && free >= 1.
- m_ready = !rst && (free >= 2 || (free == 1 && !a_valid)).
- A has priority when only one slot is free.
- Handshake: a transfer occurs when valid && ready at a posedge. The producer holds reg/data stable while valid && !ready.
- Enqueue order: when both transfer in one cycle, A's entry is written at wr_ptr and M's at wr_ptr+1. Writeback order is therefore A before M.
- Register 0: a request with reg==0 completes its handshake but is not stored. It consumes no slot and is excluded from the free computation for the other source.
- Drain: RegWrite = (count != 0), WriteReg/WriteD = head entry, driven combinationally from FIFO state.
  - The head is popped at every posedge while count != 0. The register file always accepts.
  - Latency: a request accepted at edge N appears on the write port in cycle N+1 (FIFO previously empty) and is committed to the register file at edge N+1.
- Pointers wrap modulo DEPTH.
- count_next = count + pushes - pop, where pushes is 0..2 and pop is 0..1. Simultaneous push and pop at full is legal: A is accepted only if free >= 1 before the pop.
- Lookup: qN_hit=1 iff qN_reg != 0 and any stored valid entry has a matching reg. Lookup is combinational over the current contents and excludes same-cycle incoming requests.
- Overflow/underflow cannot occur by construction. Simulation asserts count <= DEPTH.

Optional Feature:
- Macro: REGFILE_WB_FORWARD_EN.
- Defined: qN_data = data of the youngest stored entry matching qN_reg (closest to wr_ptr in age order). Valid only when qN_hit=1, else 0.
- Undefined: qN_data tied to 32'd0. Hit flags still operate, so decode must stall on a hit.

Test Plan:
- Reset mid-drain: fill 3 entries, assert rst one cycle -> next cycle count=0, RegWrite=0, q1_hit=0 for previously pending regs.
- Single write: a_valid with a_reg=5, a_data=0xDEADBEEF into empty FIFO at edge N -> cycle N+1 RegWrite=1, WriteReg=5, WriteD=0xDEADBEEF; cycle N+2 RegWrite=0.
- Simultaneous: A(r3,0x11) and M(r3,0x22) in the same cycle -> writes r3=0x11 then r3=0x22 in consecutive cycles. With FORWARD_EN, q1_reg=3 returns 0x22 while both are pending.
- Near full, DEPTH=4, count=3: a_valid and m_valid both high -> a_ready=1, m_ready=0. The next cycle with A idle and count=3 gives m_ready=1.
- r0 drop: M request with m_reg=0 -> m_ready=1, count unchanged, no RegWrite for it, and q1_reg=0 gives q1_hit=0.
- Sustained stream: A valid every cycle for 20 cycles -> a_ready never deasserts, count stays at 1 after the first cycle, and the 20 writes appear in order.
